// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : md_defs
// Description : Shared md_op encodings, default latencies and the
//               compute-op predicate for the multiply/divide path.
// Revision    : 1.0 - initial release
// ============================================================================
package md_defs;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MFHI    = 4'd5,
        MFLO    = 4'd6,
        MTHI    = 4'd7,
        MTLO    = 4'd8
    } md_op_e;

    localparam int C_MULT_LAT_DEF = 5;
    localparam int C_DIV_LAT_DEF  = 10;

    // Shared with the control unit's mdc decode so both agree on what starts a computation.
    function automatic logic is_md_compute(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : E-stage multiply/divide unit with HI/LO registers, fixed
//               multi-cycle latency and a busy flag for the stall unit.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import md_defs::*;
#(
    parameter int MULT_LAT = C_MULT_LAT_DEF,
    parameter int DIV_LAT  = C_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);

    localparam int C_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W     = $clog2(C_MAX_LAT + 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hi_t_q, hi_t_d;
    logic [31:0]      lo_t_q, lo_t_d;
    logic             dz_q, dz_d;

    logic signed [63:0] w_sa64, w_sb64, w_smul;
    logic        [63:0] w_umul;
    logic signed [32:0] w_sa33, w_sb33;
    logic        [31:0] w_b_safe;
    logic        [31:0] w_sdiv_q, w_sdiv_r, w_udiv_q, w_udiv_r;
    logic               w_b_zero;

    assign w_b_zero = (B == 32'd0);
    assign w_b_safe = w_b_zero ? 32'd1 : B;

    assign w_sa64 = {{32{A[31]}}, A};
    assign w_sb64 = {{32{B[31]}}, B};
    assign w_smul = w_sa64 * w_sb64;
    assign w_umul = {32'd0, A} * {32'd0, B};

    // 33-bit signed operands make 0x80000000 / -1 representable; the low word is the MIPS result.
    assign w_sa33   = {A[31], A};
    assign w_sb33   = w_b_zero ? 33'sd1 : {B[31], B};
    assign w_sdiv_q = 32'(w_sa33 / w_sb33);
    assign w_sdiv_r = 32'(w_sa33 % w_sb33);
    assign w_udiv_q = A / w_b_safe;
    assign w_udiv_r = A % w_b_safe;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        hi_t_d = hi_t_q;
        lo_t_d = lo_t_q;
        dz_d   = dz_q;

        if (busy_q) begin
            // Every new operation is ignored while a computation is in flight.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                if (!dz_q) begin
                    hi_d = hi_t_q;
                    lo_d = lo_t_q;
                end
            end
        end else if (start && is_md_compute(md_op)) begin
            busy_d = 1'b1;
            dz_d   = 1'b0;
            cnt_d  = CNT_W'(DIV_LAT);
            case (md_op)
                MULT: begin
                    hi_t_d = w_smul[63:32];
                    lo_t_d = w_smul[31:0];
                    cnt_d  = CNT_W'(MULT_LAT);
                end
                MULTU: begin
                    hi_t_d = w_umul[63:32];
                    lo_t_d = w_umul[31:0];
                    cnt_d  = CNT_W'(MULT_LAT);
                end
                DIV: begin
                    hi_t_d = w_sdiv_r;
                    lo_t_d = w_sdiv_q;
                    dz_d   = w_b_zero;
                end
                default: begin
                    hi_t_d = w_udiv_r;
                    lo_t_d = w_udiv_q;
                    dz_d   = w_b_zero;
                end
            endcase
        end else if (md_op == MTHI) begin
            hi_d = A;
        end else if (md_op == MTLO) begin
            lo_d = A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            hi_t_q <= 32'd0;
            lo_t_q <= 32'd0;
            dz_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            hi_t_q <= hi_t_d;
            lo_t_q <= lo_t_d;
            dz_q   <= dz_d;
        end
    end

    always_comb begin
        md_out = 32'd0;
        if (md_op == MFHI) begin
            md_out = hi_q;
        end else if (md_op == MFLO) begin
            md_out = lo_q;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit: directed scenarios plus
//               randomized operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;
    import md_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] md_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_of(input logic [3:0] op);
        return (op == MULT || op == MULTU) ? 5 : 10;
    endfunction

    // MIPS semantics written directly as 64-bit integer arithmetic.
    task automatic model_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MULT: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MULTU: begin
                u = {32'd0, a} * {32'd0, b};
                m_hi = u[63:32];
                m_lo = u[31:0];
            end
            DIV: if (b != 32'd0) begin
                m_lo = 32'(sa / sb);
                m_hi = 32'(sa % sb);
            end
            DIVU: if (b != 32'd0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] exp_md_out(input logic [3:0] op, input logic [31:0] h, input logic [31:0] l);
        return (op == MFHI) ? h : (op == MFLO) ? l : 32'd0;
    endfunction

    // mode 0: quiet, 1: random ignored traffic while busy, 2: mtlo 0x55 in cycle T+3
    task automatic run_compute(input string tag, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          lat;
        int          sel;
        old_hi = m_hi;
        old_lo = m_lo;
        lat    = lat_of(op);
        chk({tag, "_idle_before"}, 32'(busy), 32'd0);
        md_op = op;
        A     = a;
        B     = b;
        start = 1'b1;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        model_compute(op, a, b);
        for (int k = 1; k <= lat; k++) begin
            if (mode == 1 && k < lat) begin
                sel = $urandom_range(0, 4);
                A   = $urandom;
                B   = $urandom;
                case (sel)
                    0: md_op = MTHI;
                    1: md_op = MTLO;
                    2: md_op = MFHI;
                    3: md_op = MFLO;
                    default: begin
                        md_op = 4'($urandom_range(1, 4));
                        start = 1'b1;
                    end
                endcase
            end else if (mode == 2 && k == 3) begin
                md_op = MTLO;
                A     = 32'h55;
            end
            #1;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_hi_hold"}, HI, old_hi);
            chk({tag, "_lo_hold"}, LO, old_lo);
            chk({tag, "_mdout_busy"}, md_out, exp_md_out(md_op, old_hi, old_lo));
            step();
            start = 1'b0;
            md_op = MD_NONE;
        end
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_hi"}, HI, m_hi);
        chk({tag, "_lo"}, LO, m_lo);
    endtask

    task automatic do_mt(input string tag, input logic [3:0] op, input logic [31:0] a);
        md_op = op;
        A     = a;
        step();
        md_op = MD_NONE;
        if (op == MTHI) m_hi = a;
        else            m_lo = a;
        chk({tag, "_hi"}, HI, m_hi);
        chk({tag, "_lo"}, LO, m_lo);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          op_i;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        start = 1'b0;
        md_op = MD_NONE;
        A     = 32'd0;
        B     = 32'd0;
        step();
        step();
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        md_op = MFHI;
        #1;
        chk("reset_mfhi", md_out, 32'd0);
        md_op = MD_NONE;

        run_compute("mult_neg", MULT, 32'hFFFF_FFFE, 32'd3, 0);
        chk("mult_neg_hi_const", HI, 32'hFFFF_FFFF);
        chk("mult_neg_lo_const", LO, 32'hFFFF_FFFA);

        run_compute("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_hi_const", HI, 32'hFFFF_FFFE);
        chk("multu_lo_const", LO, 32'h0000_0001);

        run_compute("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_neg_lo_const", LO, 32'hFFFF_FFFD);
        chk("div_neg_hi_const", HI, 32'hFFFF_FFFF);

        run_compute("divu_7_2", DIVU, 32'd7, 32'd2, 0);
        chk("divu_lo_const", LO, 32'd3);
        chk("divu_hi_const", HI, 32'd1);

        do_mt("mtlo_idle", MTLO, 32'h1234);
        run_compute("mult_mtlo", MULT, 32'd2, 32'd3, 2);
        chk("mult_mtlo_lo_const", LO, 32'd6);

        do_mt("mthi_idle", MTHI, 32'hABCD);
        md_op = MFHI;
        #1;
        chk("mfhi_abcd", md_out, 32'hABCD);
        md_op = MFLO;
        #1;
        chk("mflo_after_mthi", md_out, m_lo);
        md_op = MD_NONE;
        #1;
        chk("mdout_none", md_out, 32'd0);

        do_mt("pre_hi", MTHI, 32'h11);
        do_mt("pre_lo", MTLO, 32'h22);
        run_compute("div_zero", DIV, 32'd1234, 32'd0, 0);
        chk("div_zero_hi_const", HI, 32'h11);
        chk("div_zero_lo_const", LO, 32'h22);
        run_compute("divu_zero", DIVU, 32'hDEAD_BEEF, 32'd0, 1);

        run_compute("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_lo_const", LO, 32'h8000_0000);
        chk("div_ovf_hi_const", HI, 32'd0);

        do_mt("pre_rst_hi", MTHI, 32'h11);
        md_op = DIV;
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("midrst_no_commit_busy", 32'(busy), 32'd0);
            chk("midrst_no_commit_hi", HI, 32'd0);
            chk("midrst_no_commit_lo", LO, 32'd0);
        end
        run_compute("mult_after_rst", MULT, 32'hFFFF_FFFE, 32'd3, 0);

        for (int it = 0; it < 30; it++) begin
            op_i = $urandom_range(0, 8);
            ra   = $urandom;
            rb   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            if (is_md_compute(4'(op_i))) begin
                if ($urandom_range(0, 3) == 0) begin
                    md_op = 4'(op_i);
                    A     = ra;
                    B     = rb;
                    start = 1'b0;
                    step();
                    md_op = MD_NONE;
                    chk("rnd_nostart_busy", 32'(busy), 32'd0);
                    chk("rnd_nostart_hi", HI, m_hi);
                    chk("rnd_nostart_lo", LO, m_lo);
                end else begin
                    run_compute("rnd_compute", 4'(op_i), ra, rb, 1);
                end
            end else if (op_i == MTHI || op_i == MTLO) begin
                do_mt("rnd_mt", 4'(op_i), ra);
            end else begin
                md_op = 4'(op_i);
                start = 1'($urandom_range(0, 1));
                A     = ra;
                #1;
                chk("rnd_mdout", md_out, exp_md_out(md_op, m_hi, m_lo));
                step();
                start = 1'b0;
                md_op = MD_NONE;
                chk("rnd_nc_busy", 32'(busy), 32'd0);
                chk("rnd_nc_hi", HI, m_hi);
                chk("rnd_nc_lo", LO, m_lo);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
